// File: rtl/keypad_decoder.sv
// keypad_decoder: aligns keypad columns to the row scan, classifies each scan
// frame, and debounces presses/releases into single-pulse key codes.
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       R1,
  input  logic       R2,
  input  logic       R3,
  input  logic       R4,
  input  logic       C1,
  input  logic       C2,
  input  logic       C3,
  input  logic       C4,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_err
);

  localparam int unsigned LINES = 4;
  localparam int unsigned CW    = 4;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DEB_PRESS, ST_HELD, ST_DEB_REL} state_e;

  logic [LINES-1:0] row_in, col_in;
  logic [LINES-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [LINES-1:0] row_d1_q, row_d1_d, row_d2_q, row_d2_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic             frame_act_q, frame_act_d;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             key_err_q, key_err_d;

  logic             frame_done;
  logic [1:0]       frame_cnt;
  logic [3:0]       frame_code;
  logic             accept_c, err_c;
  logic             res_none, res_single, res_multi;

  assign row_in = {R4, R3, R2, R1};
  assign col_in = {C4, C3, C2, C1};

  // Row/column position to key code.
  function automatic logic [3:0] map_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] c;
    c = 4'h0;
    case ({row, col})
      4'd0:  c = 4'h1;
      4'd1:  c = 4'h2;
      4'd2:  c = 4'h3;
      4'd3:  c = 4'hA;
      4'd4:  c = 4'h4;
      4'd5:  c = 4'h5;
      4'd6:  c = 4'h6;
      4'd7:  c = 4'hB;
      4'd8:  c = 4'h7;
      4'd9:  c = 4'h8;
      4'd10: c = 4'h9;
      4'd11: c = 4'hC;
      4'd12: c = 4'hF;
      4'd13: c = 4'h0;
      4'd14: c = 4'hE;
      default: c = 4'hD;
    endcase
    return c;
  endfunction

  // Column synchronizer and matching row delay line.
  always_comb begin
    col_s1_d = col_in;
    col_s2_d = col_s1_q;
    row_d1_d = row_in;
    row_d2_d = row_d1_q;
  end

  // Per-frame closure accumulation and classification on the aligned R4 cycle.
  always_comb begin
    logic [1:0] row_idx, col_idx, base_cnt, sat_cnt;
    logic [2:0] closures, sum;
    logic [3:0] base_code, code;
    logic       active;
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    frame_act_d = frame_act_q;
    frame_done  = 1'b0;
    frame_cnt   = acc_cnt_q;
    frame_code  = acc_code_q;
    row_idx     = row_d2_q[1] ? 2'd1 : row_d2_q[2] ? 2'd2 : row_d2_q[3] ? 2'd3 : 2'd0;
    col_idx     = col_s2_q[0] ? 2'd0 : col_s2_q[1] ? 2'd1 : col_s2_q[2] ? 2'd2 : 2'd3;
    closures    = 3'(col_s2_q[0]) + 3'(col_s2_q[1]) + 3'(col_s2_q[2]) + 3'(col_s2_q[3]);
    base_cnt    = row_d2_q[0] ? 2'd0 : acc_cnt_q;
    base_code   = row_d2_q[0] ? 4'h0 : acc_code_q;
    active      = row_d2_q[0] | frame_act_q;
    sum         = 3'(base_cnt) + closures;
    sat_cnt     = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code        = (base_cnt == 2'd0 && closures != 3'd0) ? map_code(row_idx, col_idx) : base_code;
    if ($onehot(row_d2_q)) begin
      if (row_d2_q[3]) begin
        frame_done  = active;
        frame_cnt   = sat_cnt;
        frame_code  = code;
        acc_cnt_d   = 2'd0;
        acc_code_d  = 4'h0;
        frame_act_d = 1'b0;
      end else begin
        acc_cnt_d   = sat_cnt;
        acc_code_d  = code;
        frame_act_d = active;
      end
    end
  end

  assign res_none   = frame_done && (frame_cnt == 2'd0);
  assign res_single = frame_done && (frame_cnt == 2'd1);
  assign res_multi  = frame_done && (frame_cnt == 2'd2);

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q    <= '0;
      col_s2_q    <= '0;
      row_d1_q    <= '0;
      row_d2_q    <= '0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      frame_act_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      row_d1_q    <= row_d1_d;
      row_d2_q    <= row_d2_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      frame_act_q <= frame_act_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      key_err_q   <= key_err_d;
    end
  end

  // Debounce FSM: advances only on completed frame results.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_c = 1'b0;
    err_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (res_single) begin
          cand_d = frame_code;
          cnt_d  = CW'(1);
          if (DEBOUNCE_FRAMES == 1) begin
            accept_c = 1'b1;
            state_d  = ST_HELD;
          end else begin
            state_d = ST_DEB_PRESS;
          end
        end else if (res_multi) begin
          err_c = 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        if (res_single) begin
          if (frame_code == cand_q) begin
            if (cnt_q >= DEB_LAST) begin
              accept_c = 1'b1;
              state_d  = ST_HELD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = CW'(1);
          end
        end else if (res_none) begin
          state_d = ST_IDLE;
        end else if (res_multi) begin
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (res_none) begin
          cnt_d   = CW'(1);
          state_d = (DEBOUNCE_FRAMES == 1) ? ST_IDLE : ST_DEB_REL;
        end
      end
      default: begin
        if (res_none) begin
          if (cnt_q >= DEB_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (res_single || res_multi) begin
          state_d = ST_HELD;
        end
      end
    endcase
  end

  // Registered outputs derived from the FSM decision.
  always_comb begin
    key_code_d  = accept_c ? frame_code : key_code_q;
    key_valid_d = accept_c;
    key_err_d   = err_c;
    key_held_d  = (state_d == ST_HELD) || (state_d == ST_DEB_REL);
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign key_err   = key_err_q;

endmodule
